vregfile: RTL and testbench

//  Parametrised vector register file; successor to the scalar regfile.

---
 rtl/vregfile.sv | 140 ++++++++++++++
 tb/tb_vregfile.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vregfile.sv
// Vector register file: combinational read ports, byte-enabled write port, busy scoreboard
// and post-reset zero-fill. Define VREGFILE_BYPASS_EN to forward same-cycle writes to reads.
module vregfile #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned VLEN         = 128,
    parameter int unsigned NUM_RD_PORTS = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    output logic                                init_done_o,
    input  logic [NUM_RD_PORTS-1:0][4:0]        rd_addr_i,
    output logic [NUM_RD_PORTS-1:0][VLEN-1:0]   rd_data_o,
    output logic [VLEN-1:0]                     mask_o,
    input  logic                                wr_en_i,
    input  logic [4:0]                          wr_addr_i,
    input  logic [VLEN-1:0]                     wr_data_i,
    input  logic [VLEN/8-1:0]                   wr_be_i,
    input  logic                                issue_en_i,
    input  logic [4:0]                          issue_rd_i,
    output logic [NUM_REGS-1:0]                 busy_o
);

    localparam int unsigned NumBytes = VLEN / 8;
    localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0]  NumRegs6 = 6'(NUM_REGS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        fill_cnt_q, fill_cnt_d;
    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic [VLEN-1:0]        mem_q [NUM_REGS];

    logic                   ready;
    logic                   wr_hit;
    logic [IdxW-1:0]        wr_idx;
    logic [VLEN-1:0]        wr_merged;

    function automatic logic in_range(input logic [4:0] addr);
        return {1'b0, addr} < NumRegs6;
    endfunction

    assign ready  = (state_q == StReady);
    assign wr_idx = wr_addr_i[IdxW-1:0];
    assign wr_hit = ready && wr_en_i && in_range(wr_addr_i);

    // Lanes without an enable keep the stored value.
    always_comb begin
        wr_merged = mem_q[wr_idx];
        for (int b = 0; b < NumBytes; b++) begin
            if (wr_be_i[b]) begin
                wr_merged[8*b +: 8] = wr_data_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            StInit: begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Clear before set so an issue in the same cycle as a commit marks the new producer.
    always_comb begin
        busy_d = busy_q;
        if (ready) begin
            if (wr_en_i && in_range(wr_addr_i)) begin
                busy_d[wr_idx] = 1'b0;
            end
            if (issue_en_i && in_range(issue_rd_i)) begin
                busy_d[issue_rd_i[IdxW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            fill_cnt_q <= '0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Storage has no reset; the zero-fill sequencer clears it after every reset.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem_q[fill_cnt_q] <= '0;
        end else if (wr_hit) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data_o[p] = '0;
            if (ready && in_range(rd_addr_i[p])) begin
                rd_data_o[p] = mem_q[rd_addr_i[p][IdxW-1:0]];
`ifdef VREGFILE_BYPASS_EN
                if (wr_hit && (rd_addr_i[p] == wr_addr_i)) begin
                    rd_data_o[p] = wr_merged;
                end
`endif
            end
        end
    end

    always_comb begin
        mask_o = '0;
        if (ready) begin
            mask_o = mem_q[0];
`ifdef VREGFILE_BYPASS_EN
            if (wr_hit && (wr_addr_i == 5'd0)) begin
                mask_o = wr_merged;
            end
`endif
        end
    end

    assign init_done_o = ready;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_vregfile.sv
// Self-checking bench for vregfile: directed scenarios plus random traffic against an
// array-based reference model of register contents, busy bits and init timing.
module tb_vregfile;

    localparam int NR = 32;
    localparam int VL = 128;
    localparam int NP = 3;
    localparam int NB = VL / 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   init_done;
    logic [NP-1:0][4:0]     rd_addr;
    logic [NP-1:0][VL-1:0]  rd_data;
    logic [VL-1:0]          mask;
    logic                   wr_en;
    logic [4:0]             wr_addr;
    logic [VL-1:0]          wr_data;
    logic [NB-1:0]          wr_be;
    logic                   issue_en;
    logic [4:0]             issue_rd;
    logic [NR-1:0]          busy;

    logic [VL-1:0]          m_reg [NR];
    logic [NR-1:0]          m_busy;
    int                     m_cyc;
    int                     n_cmp;
    int                     n_err;

    always #5 clk = ~clk;

    vregfile #(
        .NUM_REGS     (NR),
        .VLEN         (VL),
        .NUM_RD_PORTS (NP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done_o (init_done),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .mask_o      (mask),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_be_i     (wr_be),
        .issue_en_i  (issue_en),
        .issue_rd_i  (issue_rd),
        .busy_o      (busy)
    );

    function automatic logic [VL-1:0] merge(input logic [VL-1:0] old_v,
                                            input logic [VL-1:0] new_v,
                                            input logic [NB-1:0] be);
        logic [VL-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [VL-1:0] exp_read(input logic [4:0] a);
        if (m_cyc < NR) return '0;
`ifdef VREGFILE_BYPASS_EN
        if (wr_en && (a == wr_addr)) return merge(m_reg[a], wr_data, wr_be);
`endif
        return m_reg[a];
    endfunction

    function automatic logic [VL-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [VL-1:0] obs, input logic [VL-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rd%0d_v%0d", p, rd_addr[p]), rd_data[p], exp_read(rd_addr[p]));
        end
        chk("mask", mask, exp_read(5'd0));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("init_done", 128'(init_done), 128'(m_cyc >= NR));
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_reg[r] = '0;
        m_busy = '0;
        m_cyc  = 0;
    endtask

    // Drive at negedge, check combinational/registered outputs, then apply the edge to the model.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [VL-1:0] wd,
                         input logic [NB-1:0] be, input logic ie, input logic [4:0] ir,
                         input logic [14:0] ra);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        wr_be    = be;
        issue_en = ie;
        issue_rd = ir;
        rd_addr  = ra;
        #1 check_outputs();
        @(posedge clk);
        if (rst_n) begin
            if (m_cyc >= NR) begin
                if (we) begin
                    m_reg[wa]  = merge(m_reg[wa], wd, be);
                    m_busy[wa] = 1'b0;
                end
                if (ie) m_busy[ir] = 1'b1;
            end
            m_cyc++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [14:0] ra);
        cycle(1'b0, 5'd0, '0, '0, 1'b0, 5'd0, ra);
    endtask

    task automatic read_all_regs();
        for (int i = 0; i < 11; i++) begin
            idle({5'(3*i + 2), 5'(3*i + 1), 5'(3*i)});
        end
    endtask

    task automatic fill_with_noise();
        // Writes and issues during zero-fill must have no effect.
        for (int i = 0; i < NR; i++) begin
            cycle(1'b1, 5'd9, '1, '1, 1'b1, 5'(i), 15'($urandom));
        end
    endtask

    initial begin
        logic [VL-1:0] a_val;
        logic [VL-1:0] b_val;
        n_cmp    = 0;
        n_err    = 0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        rd_addr  = '0;
        model_reset();

        repeat (2) @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        fill_with_noise();
        chk("init_done_after_fill", 128'(init_done), 128'(1));
        read_all_regs();

        // Byte enables
        cycle(1'b1, 5'd3, '1, '1, 1'b0, 5'd0, {5'd3, 5'd3, 5'd3});
        cycle(1'b1, 5'd3, '0, 16'h0001, 1'b0, 5'd0, {5'd3, 5'd3, 5'd3});
        cycle(1'b1, 5'd3, rnd128(), 16'h0000, 1'b0, 5'd0, {5'd3, 5'd3, 5'd3});
        idle({5'd3, 5'd3, 5'd3});
        #1 chk("v3_byte0_cleared", rd_data[0], {{120{1'b1}}, 8'h00});

        // Scoreboard
        cycle(1'b0, 5'd0, '0, '0, 1'b1, 5'd5, '0);
        cycle(1'b1, 5'd5, rnd128(), '0, 1'b0, 5'd0, '0);
        cycle(1'b1, 5'd5, rnd128(), '1, 1'b1, 5'd5, {5'd5, 5'd1, 5'd2});
        cycle(1'b0, 5'd0, '0, '0, 1'b1, 5'd5, '0);
        idle('0);
        #1 chk("busy5_set_wins", 128'(busy[5]), 128'(1));

        // Same-cycle read of a register being written
        a_val = rnd128();
        b_val = rnd128();
        cycle(1'b1, 5'd7, a_val, '1, 1'b0, 5'd0, {5'd7, 5'd7, 5'd7});
        cycle(1'b1, 5'd7, b_val, '1, 1'b0, 5'd0, {5'd7, 5'd7, 5'd7});
        idle({5'd7, 5'd0, 5'd7});
        #1 chk("v7_next_cycle", rd_data[0], b_val);

        // v0 is an ordinary register and drives mask_o
        cycle(1'b1, 5'd0, 128'h0123456789ABCDEF0123456789ABCDEF, '1, 1'b0, 5'd0,
              {5'd0, 5'd0, 5'd0});
        idle({5'd0, 5'd0, 5'd0});
        #1 chk("mask_v0", mask, 128'h0123456789ABCDEF0123456789ABCDEF);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 5'($urandom), rnd128(), 16'($urandom), 1'($urandom),
                  5'($urandom), 15'($urandom));
        end

        // Asynchronous reset in the middle of a cycle
        cycle(1'b1, 5'd4, '1, '1, 1'b1, 5'd6, {5'd4, 5'd6, 5'd0});
        wr_en    = 1'b0;
        issue_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_with_noise();
        read_all_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
